// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: 2:1 round-robin OBI arbiter with request lock; an ID FIFO routes in-order responses back to the issuer.
// Zero added latency on request/response paths; s_req_o drops while MAX_OUTST responses are pending. Perf counters: OBI_ARB_PERF_CNT_EN.
module obi_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
`ifdef OBI_ARB_PERF_CNT_EN
  output logic [CNT_W-1:0]    perf_gnt0_o,
  output logic [CNT_W-1:0]    perf_gnt1_o,
`endif
  input  logic                m0_req_i,
  output logic                m0_gnt_o,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  output logic                m1_gnt_o,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                s_req_o,
  input  logic                s_gnt_i,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_be_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  input  logic                s_rvalid_i,
  input  logic [DATA_W-1:0]   s_rdata_i
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_FW = $clog2(MAX_OUTST + 1);

  if (MAX_OUTST < 1 || CNT_W < 1) begin : g_param_check
    $error("obi_mem_arbiter: MAX_OUTST and CNT_W must be >= 1");
  end

  logic                 rr_q, rr_d;
  logic                 lock_q, lock_d;
  logic                 lock_id_q, lock_id_d;
  logic [MAX_OUTST-1:0] id_fifo_q, id_fifo_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0]    cnt_q, cnt_d;

  logic winner, full, push, pop, head_id, sel_m1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    if (lock_q) begin
      winner = lock_id_q;
    end else if (m0_req_i ^ m1_req_i) begin
      winner = m1_req_i;
    end else begin
      winner = rr_q;
    end
  end

  // No bypass: a pop in the same cycle does not free a slot for this cycle's request.
  assign full    = (cnt_q == CNT_FW'(MAX_OUTST));
  assign s_req_o = (m0_req_i | m1_req_i) & ~full & ~rst_i;
  assign push    = s_req_o & s_gnt_i;
  assign pop     = s_rvalid_i & (cnt_q != '0) & ~rst_i;
  assign head_id = id_fifo_q[rd_ptr_q];
  assign sel_m1  = winner & ~rst_i;

  assign s_addr_o  = sel_m1 ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = sel_m1 ? m1_we_i    : m0_we_i;
  assign s_be_o    = sel_m1 ? m1_be_i    : m0_be_i;
  assign s_wdata_o = sel_m1 ? m1_wdata_i : m0_wdata_i;

  assign m0_gnt_o    = push & ~winner;
  assign m1_gnt_o    = push & winner;
  assign m0_rvalid_o = pop & ~head_id;
  assign m1_rvalid_o = pop & head_id;
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

  always_comb begin
    rr_d      = rr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    id_fifo_d = id_fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    if (push) begin
      id_fifo_d[wr_ptr_q] = winner;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
      rr_d                = ~winner;
      lock_d              = 1'b0;
    end else if (s_req_o) begin
      // Stalled: hold this choice until the memory accepts it.
      lock_d    = 1'b1;
      lock_id_d = winner;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q      <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      id_fifo_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      id_fifo_q <= id_fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef OBI_ARB_PERF_CNT_EN
  logic [CNT_W-1:0] perf_gnt0_q, perf_gnt0_d;
  logic [CNT_W-1:0] perf_gnt1_q, perf_gnt1_d;

  always_comb begin
    perf_gnt0_d = perf_gnt0_q;
    perf_gnt1_d = perf_gnt1_q;
    if (m0_gnt_o && (perf_gnt0_q != '1)) perf_gnt0_d = perf_gnt0_q + 1'b1;
    if (m1_gnt_o && (perf_gnt1_q != '1)) perf_gnt1_d = perf_gnt1_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_gnt0_q <= '0;
      perf_gnt1_q <= '0;
    end else begin
      perf_gnt0_q <= perf_gnt0_d;
      perf_gnt1_q <= perf_gnt1_d;
    end
  end

  assign perf_gnt0_o = perf_gnt0_q;
  assign perf_gnt1_o = perf_gnt1_q;
`endif

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Bench for obi_mem_arbiter: directed vector table, hand sequences, then randomized traffic against a queue-based model.
module tb_obi_mem_arbiter;

  localparam int MAX_OUTST = 2;

  logic        clk, rst;
  logic        m0_req, m0_gnt, m0_we, m0_rvalid;
  logic        m1_req, m1_gnt, m1_we, m1_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_be, m1_be, s_be;
  logic        s_req, s_gnt, s_we, s_rvalid;
  logic [31:0] s_addr, s_wdata, s_rdata;
`ifdef OBI_ARB_PERF_CNT_EN
  logic [31:0] perf0, perf1;
  logic [1:0]  d2_perf0, d2_perf1;
  logic        d2_g0, d2_g1, d2_rv0, d2_rv1, d2_req, d2_we;
  logic [31:0] d2_rd0, d2_rd1, d2_addr, d2_wdata;
  logic [3:0]  d2_be;
`endif

  int n_vec = 0;
  int n_err = 0;

  obi_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(MAX_OUTST), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
`ifdef OBI_ARB_PERF_CNT_EN
    .perf_gnt0_o(perf0), .perf_gnt1_o(perf1),
`endif
    .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
    .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
    .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be),
    .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata)
  );

`ifdef OBI_ARB_PERF_CNT_EN
  obi_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(MAX_OUTST), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst),
    .perf_gnt0_o(d2_perf0), .perf_gnt1_o(d2_perf1),
    .m0_req_i(m0_req), .m0_gnt_o(d2_g0), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
    .m0_wdata_i(m0_wdata), .m0_rvalid_o(d2_rv0), .m0_rdata_o(d2_rd0),
    .m1_req_i(m1_req), .m1_gnt_o(d2_g1), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
    .m1_wdata_i(m1_wdata), .m1_rvalid_o(d2_rv1), .m1_rdata_o(d2_rd1),
    .s_req_o(d2_req), .s_gnt_i(s_gnt), .s_addr_o(d2_addr), .s_we_o(d2_we), .s_be_o(d2_be),
    .s_wdata_o(d2_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        sreq, g0, g1, rv0, rv1;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata, rdata;
  } exp_t;

  typedef struct {
    bit          rst, r0, r1;
    logic [31:0] a0, a1;
    bit          sg, srv;
    logic [31:0] srd;
    logic [4:0]  e_ctl;   // {s_req, gnt0, gnt1, rvalid0, rvalid1}
    bit          e_win;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[$];

  // m0 issues reads with full byte enables, m1 issues writes with half enables.
  function automatic exp_t mkexp(input logic win, input logic [31:0] addr,
                                 input logic [4:0] ctl, input logic [31:0] rd);
    exp_t e;
    e.sreq  = ctl[4];
    e.g0    = ctl[3];
    e.g1    = ctl[2];
    e.rv0   = ctl[1];
    e.rv1   = ctl[0];
    e.addr  = addr;
    e.we    = win;
    e.be    = win ? 4'h3 : 4'hF;
    e.wdata = addr ^ (win ? 32'hA5A50000 : 32'h5A5A0000);
    e.rdata = rd;
    return e;
  endfunction

  function automatic vec_t mk(input bit rst_v, r0, r1, input logic [31:0] a0, a1,
                              input bit sg, srv, input logic [31:0] srd,
                              input logic [4:0] ctl, input bit win, input logic [31:0] addr);
    vec_t v;
    v.rst = rst_v; v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1;
    v.sg = sg; v.srv = srv; v.srd = srd; v.e_ctl = ctl; v.e_win = win; v.e_addr = addr;
    return v;
  endfunction

  task automatic set_in(input bit rst_v, r0, r1, input logic [31:0] a0, a1,
                        input bit sg, srv, input logic [31:0] srd);
    rst = rst_v;
    m0_req = r0; m0_addr = a0; m0_we = 1'b0; m0_be = 4'hF; m0_wdata = a0 ^ 32'h5A5A0000;
    m1_req = r1; m1_addr = a1; m1_we = 1'b1; m1_be = 4'h3; m1_wdata = a1 ^ 32'hA5A50000;
    s_gnt = sg; s_rvalid = srv; s_rdata = srd;
  endtask

  task automatic check(input string name, input exp_t e);
    bit ok;
    ok = ({s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} === {e.sreq, e.g0, e.g1, e.rv0, e.rv1});
    if (e.sreq)
      ok = ok && (s_addr === e.addr) && (s_we === e.we) && (s_be === e.be) && (s_wdata === e.wdata);
    if (e.rv0 || e.rv1)
      ok = ok && (m0_rdata === e.rdata) && (m1_rdata === e.rdata);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got req,g0,g1,rv0,rv1=%b%b%b%b%b addr=%h we=%b be=%h wdata=%h rdata=%h/%h; want %b%b%b%b%b addr=%h we=%b be=%h wdata=%h rdata=%h",
               name, s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_addr, s_we, s_be, s_wdata,
               m0_rdata, m1_rdata, e.sreq, e.g0, e.g1, e.rv0, e.rv1, e.addr, e.we, e.be, e.wdata, e.rdata);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic tick_check(input string name, input exp_t e);
    @(negedge clk);
    check(name, e);
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    int   q[$];
    int   waiting, last_gnt, w, head, perf_m0, perf_m1;
    bit   r0, r1, pend0, pend1, rst_v, sg, srv, any, esreq, hs, pop;
    logic [31:0] ra0, ra1, srd;

    // Directed table: reset, contention, spurious rvalid, lock, full, reset mid-flight.
    tbl.push_back(mk(1,1,1, 32'h100, 32'h200, 1,0, 32'h0,        5'b00000, 0, 32'h100));
    tbl.push_back(mk(1,1,1, 32'h100, 32'h200, 1,1, 32'h1234,     5'b00000, 0, 32'h100));
    tbl.push_back(mk(0,1,1, 32'h100, 32'h200, 1,0, 32'h0,        5'b11000, 0, 32'h100));
    tbl.push_back(mk(0,1,1, 32'h100, 32'h200, 1,1, 32'hA0,       5'b10110, 1, 32'h200));
    tbl.push_back(mk(0,1,1, 32'h100, 32'h200, 1,1, 32'hA1,       5'b11001, 0, 32'h100));
    tbl.push_back(mk(0,1,1, 32'h100, 32'h200, 1,1, 32'hA2,       5'b10110, 1, 32'h200));
    tbl.push_back(mk(0,0,0, 32'h100, 32'h200, 1,1, 32'hA3,       5'b00001, 0, 32'h100));
    tbl.push_back(mk(0,0,0, 32'h100, 32'h200, 1,1, 32'hDEADBEEF, 5'b00000, 0, 32'h100));
    tbl.push_back(mk(0,0,1, 32'h300, 32'h1F00, 0,0, 32'h0,       5'b10000, 1, 32'h1F00));
    tbl.push_back(mk(0,1,1, 32'h300, 32'h1F00, 0,0, 32'h0,       5'b10000, 1, 32'h1F00));
    tbl.push_back(mk(0,1,1, 32'h300, 32'h1F00, 0,0, 32'h0,       5'b10000, 1, 32'h1F00));
    tbl.push_back(mk(0,1,1, 32'h300, 32'h1F00, 1,0, 32'h0,       5'b10100, 1, 32'h1F00));
    tbl.push_back(mk(0,1,0, 32'h300, 32'h1F00, 1,0, 32'h0,       5'b11000, 0, 32'h300));
    tbl.push_back(mk(0,1,1, 32'h300, 32'h1F00, 1,0, 32'h0,       5'b00000, 0, 32'h300));
    tbl.push_back(mk(0,1,1, 32'h300, 32'h1F00, 1,1, 32'hB0,      5'b00001, 0, 32'h300));
    tbl.push_back(mk(0,1,1, 32'h300, 32'h1F00, 1,0, 32'h0,       5'b10100, 1, 32'h1F00));
    tbl.push_back(mk(0,1,1, 32'h300, 32'h1F00, 1,1, 32'hB1,      5'b00010, 0, 32'h300));
    tbl.push_back(mk(0,1,1, 32'h300, 32'h1F00, 1,1, 32'hB2,      5'b11001, 0, 32'h300));
    tbl.push_back(mk(0,0,0, 32'h300, 32'h1F00, 1,1, 32'hB3,      5'b00010, 0, 32'h300));
    tbl.push_back(mk(0,1,0, 32'h300, 32'h1F00, 1,0, 32'h0,       5'b11000, 0, 32'h300));
    tbl.push_back(mk(1,1,1, 32'h300, 32'h1F00, 1,0, 32'h0,       5'b00000, 0, 32'h300));
    tbl.push_back(mk(0,0,0, 32'h300, 32'h1F00, 1,1, 32'hC0,      5'b00000, 0, 32'h300));
    tbl.push_back(mk(0,1,1, 32'h300, 32'h1F00, 1,0, 32'h0,       5'b11000, 0, 32'h300));
    tbl.push_back(mk(0,0,0, 32'h300, 32'h1F00, 1,1, 32'hC1,      5'b00010, 0, 32'h300));

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].rst, tbl[i].r0, tbl[i].r1, tbl[i].a0, tbl[i].a1, tbl[i].sg, tbl[i].srv, tbl[i].srd);
      tick_check($sformatf("vec%0d", i), mkexp(tbl[i].e_win, tbl[i].e_addr, tbl[i].e_ctl, tbl[i].srd));
    end

    // Reset while m1 holds a lock: the lock must not survive reset.
    set_in(0,0,1, 32'h300, 32'h1F00, 0,0, 32'h0);
    tick_check("lock_before_rst", mkexp(1, 32'h1F00, 5'b10000, 32'h0));
    set_in(1,1,1, 32'h300, 32'h1F00, 1,0, 32'h0);
    tick_check("lock_in_rst", mkexp(0, 32'h300, 5'b00000, 32'h0));
    set_in(0,1,1, 32'h300, 32'h1F00, 1,0, 32'h0);
    tick_check("lock_after_rst", mkexp(0, 32'h300, 5'b11000, 32'h0));
    set_in(0,0,0, 32'h300, 32'h1F00, 1,1, 32'hD0);
    tick_check("lock_after_rsp", mkexp(0, 32'h300, 5'b00010, 32'hD0));

`ifdef OBI_ARB_PERF_CNT_EN
    set_in(1,0,0, 32'h0, 32'h0, 0,0, 32'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      set_in(0,1,0, 32'h400 + 32'(4*i), 32'h0, 1, (i > 0), 32'h0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      set_in(0,0,1, 32'h0, 32'h500 + 32'(4*i), 1,1, 32'h0);
      step();
    end
    set_in(0,0,0, 32'h0, 32'h0, 1,1, 32'h0);
    step();
    set_in(0,0,0, 32'h0, 32'h0, 0,0, 32'h0);
    step();
    check_val("perf_gnt0", perf0, 32'd5);
    check_val("perf_gnt1", perf1, 32'd3);
    check_val("perf_gnt0_sat", {30'd0, d2_perf0}, 32'd3);
    check_val("perf_gnt1_sat", {30'd0, d2_perf1}, 32'd3);
`endif

    // Randomized traffic: masters hold req/fields until granted, as OBI requires.
    waiting = -1; last_gnt = 1; pend0 = 0; pend1 = 0; perf_m0 = 0; perf_m1 = 0;
    r0 = 0; r1 = 0; ra0 = 32'h0; ra1 = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      rst_v = (i == 0) || ($urandom_range(0, 99) == 0);
      if (!pend0) begin r0 = ($urandom_range(0, 9) < 6); ra0 = $urandom; end
      if (!pend1) begin r1 = ($urandom_range(0, 9) < 6); ra1 = $urandom; end
      sg  = ($urandom_range(0, 9) < 7);
      srv = ($urandom_range(0, 1) == 1);
      srd = $urandom;
      set_in(rst_v, r0, r1, ra0, ra1, sg, srv, srd);

      // A stalled choice keeps priority; otherwise a lone requester wins, else the one not served last.
      any = r0 | r1;
      if (waiting >= 0)  w = waiting;
      else if (r0 && !r1) w = 0;
      else if (r1 && !r0) w = 1;
      else               w = 1 - last_gnt;
      esreq = !rst_v && any && (q.size() < MAX_OUTST);
      hs    = esreq && sg;
      pop   = !rst_v && srv && (q.size() > 0);
      head  = pop ? q[0] : 0;

      @(negedge clk);
      check($sformatf("rand%0d", i),
            mkexp(w[0], (w == 1) ? ra1 : ra0,
                  {esreq, hs && (w == 0), hs && (w == 1), pop && (head == 0), pop && (head == 1)}, srd));

      if (rst_v) begin
        q.delete();
        waiting = -1; last_gnt = 1; perf_m0 = 0; perf_m1 = 0;
      end else begin
        if (pop) void'(q.pop_front());
        if (hs) begin
          q.push_back(w);
          last_gnt = w;
          waiting  = -1;
          if (w == 0) perf_m0++; else perf_m1++;
        end else if (esreq) begin
          waiting = w;
        end
      end
      pend0 = !rst_v && r0 && !(hs && (w == 0));
      pend1 = !rst_v && r1 && !(hs && (w == 1));
      @(posedge clk); #1;
    end

`ifdef OBI_ARB_PERF_CNT_EN
    check_val("perf_gnt0_rand", perf0, 32'(perf_m0));
    check_val("perf_gnt1_rand", perf1, 32'(perf_m1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
